// File: rtl/uart_image_loader_pkg.sv
// Package uart_loader_pkg: shared types and constants for the UART image loader.
//   loader_state_e : FSM state encoding (IDLE, WAIT, WRITE, CHECK, DONE)
//   PAD_BYTE       : upper byte used to zero-extend each pixel to a 16-bit word
`timescale 1ns/1ps
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      WRITE,
      CHECK,
      DONE
   } loader_state_e;

   localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/uart_image_loader_if.sv
// Interface uart_image_loader_if: receive handshake plus memory write bus.
//   rx_ready     : receiver holds a byte (level until cleared)
//   rx_data      : receiver word, only [7:0] carries the byte
//   rx_ready_clr : one-cycle pulse clearing rx_ready
//   mem_we       : memory write strobe
//   mem_addr     : write address (ADDR_W bits)
//   mem_wdata    : write data, zero-extended byte
// Modports: master = loader side, slave = receiver/memory side.
`timescale 1ns/1ps
interface uart_image_loader_if #(
   parameter int unsigned ADDR_W = 16
);

   logic              rx_ready;
   logic [15:0]       rx_data;
   logic              rx_ready_clr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport master (
      input  rx_ready, rx_data,
      output rx_ready_clr, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_ready, rx_data,
      input  rx_ready_clr, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/uart_image_loader.sv
// Module uart_image_loader: drains received UART bytes and writes them as
// zero-extended 16-bit words to consecutive addresses from BASE_ADDR.
// One start pulse loads IMG_BYTES bytes; busy/done report progress.
// Ports:
//   clk_50m  : system clock (rising edge)
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle load request, ignored unless idle
//   bus      : uart_image_loader_if.master (rx handshake + memory write)
//   busy     : load in progress
//   done     : load complete, held until the next accepted start
//   csum_err : trailer checksum mismatch, held with done
// Optional feature macro: LOADER_CHECKSUM_EN (trailer byte checked against
// the mod-256 sum of the payload; without it csum_err is constant 0).
`timescale 1ns/1ps
module uart_image_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       IMG_BYTES = 65536
) (
   input  logic                       clk_50m,
   input  logic                       rst_n,
   input  logic                       start,
   uart_image_loader_if.master        bus,
   output logic                       busy,
   output logic                       done,
   output logic                       csum_err
);

   localparam int unsigned      CNT_W    = $clog2(IMG_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_BYTES - 1);

   loader_state_e    state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       byte_q,  byte_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic [ADDR_W-1:0] wr_addr;
   logic              in_write;
   logic [7:0]        unused_rx_hi;

   assign unused_rx_hi = bus.rx_data[15:8];
   assign wr_addr      = BASE_ADDR + ADDR_W'(count_q);
   assign in_write     = (state_q == WRITE);

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q,  sum_d;
   logic       csum_q, csum_d;
   // The trailer clear is registered so no path exists from rx_ready to outputs.
   logic       tclr_q, tclr_d;
`endif

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         byte_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
         csum_q  <= 1'b0;
         tclr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         csum_q  <= csum_d;
         tclr_q  <= tclr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      byte_d  = byte_q;
      busy_d  = busy_q;
      done_d  = done_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      csum_d  = csum_q;
      tclr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               count_d = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
               csum_d  = 1'b0;
`endif
            end
         end
         WAIT: begin
            if (bus.rx_ready) begin
               byte_d  = bus.rx_data[7:0];
               state_d = WRITE;
            end
         end
         WRITE: begin
            count_d = count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + byte_q;
            state_d = (count_q == LAST_CNT) ? CHECK : WAIT;
`else
            state_d = (count_q == LAST_CNT) ? DONE : WAIT;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (bus.rx_ready) begin
               tclr_d  = 1'b1;
               csum_d  = (bus.rx_data[7:0] != sum_q);
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_we    = in_write;
   assign bus.mem_addr  = in_write ? wr_addr : '0;
   assign bus.mem_wdata = in_write ? {PAD_BYTE, byte_q} : '0;
   assign busy          = busy_q;
   assign done          = done_q;

`ifdef LOADER_CHECKSUM_EN
   assign bus.rx_ready_clr = in_write | tclr_q;
   assign csum_err         = csum_q;
`else
   assign bus.rx_ready_clr = in_write;
   assign csum_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_image_loader.sv
// Testbench for uart_image_loader: two instances (16-bit address at 0x0100,
// and 4-bit address at 0xE to show wrap-around), both loading 4 bytes.
// Expected writes are queued when a byte is offered and popped on mem_we.
`timescale 1ns/1ps
module tb_uart_image_loader;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst_n, start0, start1;
   logic busy0, done0, csum0, busy1, done1, csum1;

   uart_image_loader_if #(.ADDR_W(16)) bus ();
   uart_image_loader_if #(.ADDR_W(4))  bus2 ();

   uart_image_loader #(.ADDR_W(16), .BASE_ADDR(16'h0100), .IMG_BYTES(4)) dut (
      .clk_50m(clk), .rst_n(rst_n), .start(start0), .bus(bus.master),
      .busy(busy0), .done(done0), .csum_err(csum0));

   uart_image_loader #(.ADDR_W(4), .BASE_ADDR(4'hE), .IMG_BYTES(4)) dut2 (
      .clk_50m(clk), .rst_n(rst_n), .start(start1), .bus(bus2.master),
      .busy(busy1), .done(done1), .csum_err(csum1));

`ifdef LOADER_CHECKSUM_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t q0[$];
   wr_t q1[$];
   int  total = 0;
   int  bad   = 0;
   int  wr0 = 0, wr1 = 0, clr0 = 0, clr1 = 0;
   int  idx0 = 0, idx1 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_csum(input logic [7:0] sum, input logic [7:0] trailer);
`ifdef LOADER_CHECKSUM_EN
      return sum != trailer;
`else
      return (sum == trailer) && 1'b0;
`endif
   endfunction

   // write monitors / scoreboard consumers
   always @(negedge clk) begin
      wr_t e;
      if (bus.mem_we === 1'b1) begin
         wr0++;
         check("wr0_expected", {31'd0, q0.size() > 0}, 32'd1);
         check("wr0_clr_with_we", {31'd0, bus.rx_ready_clr}, 32'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("wr0_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
            check("wr0_data", {16'd0, bus.mem_wdata}, {16'd0, e.data});
         end
      end
      if (bus.rx_ready_clr === 1'b1) clr0++;
   end

   always @(negedge clk) begin
      wr_t e;
      if (bus2.mem_we === 1'b1) begin
         wr1++;
         check("wr1_expected", {31'd0, q1.size() > 0}, 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("wr1_addr", {28'd0, bus2.mem_addr}, {16'd0, e.addr});
            check("wr1_data", {16'd0, bus2.mem_wdata}, {16'd0, e.data});
         end
      end
      if (bus2.rx_ready_clr === 1'b1) clr1++;
   end

   task automatic drive_rx(input int which, input logic rdy, input logic [15:0] d);
      if (which == 0) begin
         bus.rx_ready = rdy;  bus.rx_data = d;
      end else begin
         bus2.rx_ready = rdy; bus2.rx_data = d;
      end
   endtask

   // Offer one byte like the receiver does: hold rx_ready until the clear pulse.
   task automatic feed_byte(input int which, input logic [7:0] b, input bit push);
      wr_t e;
      int  lat;
      bit  seen;
      @(negedge clk);
      drive_rx(which, 1'b1, {8'hA5, b});
      if (push) begin
         e.data = {8'h00, b};
         if (which == 0) begin
            e.addr = 16'h0100 + 16'(idx0);
            idx0++;
            q0.push_back(e);
         end else begin
            e.addr = {12'h000, 4'(4'hE + idx1)};
            idx1++;
            q1.push_back(e);
         end
      end
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (((which == 0) ? bus.rx_ready_clr : bus2.rx_ready_clr) === 1'b1) seen = 1'b1;
      end
      check("clr_latency", 32'(lat), 32'd1);
      @(posedge clk);
      #1;
      drive_rx(which, 1'b0, 16'h0000);
   endtask

   task automatic pulse_start(input int which, input bit accept);
      @(negedge clk);
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (which == 0) begin
         check("start_busy0", {31'd0, busy0}, 32'd1);
         if (accept) begin
            idx0 = 0;
            check("start_done0", {31'd0, done0}, 32'd0);
            check("start_csum0", {31'd0, csum0}, 32'd0);
         end
      end else begin
         check("start_busy1", {31'd0, busy1}, 32'd1);
         if (accept) idx1 = 0;
      end
   endtask

   task automatic wait_done(input int which);
      for (int i = 0; i < 10; i++) begin
         if (((which == 0) ? done0 : done1) === 1'b1) break;
         @(negedge clk);
      end
      check("done_set",   {31'd0, (which == 0) ? done0 : done1}, 32'd1);
      check("busy_clear", {31'd0, (which == 0) ? busy0 : busy1}, 32'd0);
   endtask

   task automatic finish_load(input int which, input logic [7:0] trailer);
`ifdef LOADER_CHECKSUM_EN
      feed_byte(which, trailer, 1'b0);
`else
      if (trailer === 8'hxx) check("trailer_known", 32'd0, 32'd1);
`endif
      wait_done(which);
   endtask

   task automatic chk_reset_outputs();
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      check("rst_done0", {31'd0, done0}, 32'd0);
      check("rst_we0",   {31'd0, bus.mem_we}, 32'd0);
      check("rst_clr0",  {31'd0, bus.rx_ready_clr}, 32'd0);
      check("rst_csum0", {31'd0, csum0}, 32'd0);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
      check("rst_we1",   {31'd0, bus2.mem_we}, 32'd0);
   endtask

   initial begin
      int snap_wr, snap_clr;
      logic [7:0] pay2 [4];
      logic [7:0] pay5 [4];
      pay2 = '{8'h11, 8'h22, 8'h33, 8'h44};
      pay5 = '{8'h01, 8'h02, 8'h03, 8'h04};

      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      drive_rx(0, 1'b0, 16'h0000);
      drive_rx(1, 1'b0, 16'h0000);

      // reset held for 3 cycles
      repeat (3) begin
         @(negedge clk);
         chk_reset_outputs();
      end
      rst_n = 1'b1;

      // basic load with idle gaps between bytes
      pulse_start(0, 1'b1);
      snap_wr  = wr0;
      snap_clr = clr0;
      for (int i = 0; i < 4; i++) begin
         repeat (2) @(negedge clk);
         feed_byte(0, pay2[i], 1'b1);
      end
`ifndef LOADER_CHECKSUM_EN
      // Now in DONE; a start here must be ignored.
      start0 = 1'b1;
      @(negedge clk);
      check("done_state_busy", {31'd0, busy0}, 32'd1);
      check("done_state_done", {31'd0, done0}, 32'd0);
      @(posedge clk);
      #1;
      start0 = 1'b0;
      @(negedge clk);
      check("after_done_busy", {31'd0, busy0}, 32'd0);
      check("after_done_done", {31'd0, done0}, 32'd1);
`else
      finish_load(0, 8'hAA);
`endif
      check("t2_writes", 32'(wr0 - snap_wr), 32'd4);
      check("t2_clears", 32'(clr0 - snap_clr), 32'(4 + TRL));
      check("t2_csum", {31'd0, csum0}, {31'd0, exp_csum(8'hAA, 8'hAA)});
      repeat (3) @(negedge clk);
      check("done_hold", {31'd0, done0}, 32'd1);

      // back-to-back bytes
      pulse_start(0, 1'b1);
      snap_wr  = wr0;
      snap_clr = clr0;
      feed_byte(0, 8'h5A, 1'b1);
      feed_byte(0, 8'hA5, 1'b1);
      feed_byte(0, 8'hFF, 1'b1);
      feed_byte(0, 8'h00, 1'b1);
      finish_load(0, 8'hFE);
      check("t3_writes", 32'(wr0 - snap_wr), 32'd4);
      check("t3_clears", 32'(clr0 - snap_clr), 32'(4 + TRL));

      // mid-load start ignored, then reset aborts the load
      pulse_start(0, 1'b1);
      feed_byte(0, 8'h71, 1'b1);
      pulse_start(0, 1'b0);
      feed_byte(0, 8'h72, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_we",   {31'd0, bus.mem_we}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_start(0, 1'b1);
      snap_wr = wr0;
      for (int i = 0; i < 4; i++) feed_byte(0, 8'h81 + 8'(i), 1'b1);
      finish_load(0, 8'h0A);
      check("t4_writes", 32'(wr0 - snap_wr), 32'd4);

      // checksum: good trailer, then bad trailer
      pulse_start(0, 1'b1);
      snap_wr = wr0;
      for (int i = 0; i < 4; i++) feed_byte(0, pay5[i], 1'b1);
      finish_load(0, 8'h0A);
      check("t5_csum_ok", {31'd0, csum0}, {31'd0, exp_csum(8'h0A, 8'h0A)});
      check("t5_writes_ok", 32'(wr0 - snap_wr), 32'd4);
      pulse_start(0, 1'b1);
      snap_wr = wr0;
      for (int i = 0; i < 4; i++) feed_byte(0, pay5[i], 1'b1);
      finish_load(0, 8'h0B);
      check("t5_csum_bad", {31'd0, csum0}, {31'd0, exp_csum(8'h0A, 8'h0B)});
      check("t5_writes_bad", 32'(wr0 - snap_wr), 32'd4);
      repeat (3) @(negedge clk);
      check("t5_csum_hold", {31'd0, csum0}, {31'd0, exp_csum(8'h0A, 8'h0B)});
      pulse_start(0, 1'b1);
      for (int i = 0; i < 4; i++) feed_byte(0, 8'h10, 1'b1);
      finish_load(0, 8'h40);

      // 4-bit address wrap on the second instance
      pulse_start(1, 1'b1);
      snap_wr = wr1;
      feed_byte(1, 8'hC1, 1'b1);
      feed_byte(1, 8'hC2, 1'b1);
      feed_byte(1, 8'hC3, 1'b1);
      feed_byte(1, 8'hC4, 1'b1);
      finish_load(1, 8'h0A);
      check("t6_writes", 32'(wr1 - snap_wr), 32'd4);
      check("t6_csum", {31'd0, csum1}, {31'd0, exp_csum(8'h0A, 8'h0A)});

      repeat (2) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
